// File: rtl/flat_io_serdes.sv
// Serial-to-parallel stimulus loader and parallel-to-serial response shifter
// that sits between a 1-bit stream link and a flattened-IO harness wrapper.
module flat_io_serdes #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in_valid,
  output logic             s_in_ready,
  input  logic             s_in_bit,
  output logic [IN_W-1:0]  dut_in_flat,
  input  logic [OUT_W-1:0] dut_out_flat,
  output logic             s_out_valid,
  input  logic             s_out_ready,
  output logic             s_out_bit,
  output logic             s_out_last,
  output logic             busy
);

  // state     | meaning
  // ST_LOAD   | accepting stimulus bits into staging
  // ST_WAIT   | vector applied, waiting SETTLE cycles for wrapper
  // ST_SHIFT  | presenting sampled response MSB first
  localparam int MAX_A = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int MAX_V = (MAX_A > SETTLE) ? MAX_A : SETTLE;
  localparam int CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] IN_LAST     = CW'(IN_W - 1);
  localparam logic [CW-1:0] OUT_LAST    = CW'(OUT_W - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]  staging_q, staging_d;
  logic [IN_W-1:0]  din_q, din_d;
  logic [OUT_W-1:0] outreg_q, outreg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      staging_q <= '0;
      din_q     <= '0;
      outreg_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      staging_q <= staging_d;
      din_q     <= din_d;
      outreg_q  <= outreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    staging_d = staging_q;
    din_d     = din_q;
    outreg_d  = outreg_q;
    case (state_q)
      ST_LOAD: begin
        if (s_in_valid) begin
          staging_d = (staging_q << 1) | IN_W'(s_in_bit);
          // The whole vector lands on the wrapper at once, never partially.
          if (cnt_q == IN_LAST) begin
            din_d   = staging_d;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          outreg_d = dut_out_flat;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        if (s_out_ready) begin
          outreg_d = outreg_q << 1;
          if (cnt_q == OUT_LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  assign dut_in_flat = din_q;
  assign s_in_ready  = (state_q == ST_LOAD);
  assign s_out_valid = (state_q == ST_SHIFT);
  assign s_out_bit   = (state_q == ST_SHIFT) & outreg_q[OUT_W-1];
  assign s_out_last  = (state_q == ST_SHIFT) & (cnt_q == OUT_LAST);
  assign busy        = (state_q != ST_LOAD);

endmodule

// File: tb/tb_flat_io_serdes.sv
// Bench for flat_io_serdes driving an adder-style wrapper (out = in[3:2] + in[1:0]),
// compared every cycle against a queue-based transaction model.
module tb_flat_io_serdes;
  localparam int IN_W   = 4;
  localparam int OUT_W  = 3;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             s_in_valid = 1'b0;
  logic             s_in_bit = 1'b0;
  logic             s_out_ready = 1'b0;
  logic             s_in_ready, s_out_valid, s_out_bit, s_out_last, busy;
  logic [IN_W-1:0]  dut_in_flat;
  logic [OUT_W-1:0] dut_out_flat;
  logic [OUT_W-1:0] garble = '0;

  int checks = 0;
  int errors = 0;

  flat_io_serdes #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_in_valid(s_in_valid), .s_in_ready(s_in_ready), .s_in_bit(s_in_bit),
    .dut_in_flat(dut_in_flat), .dut_out_flat(dut_out_flat),
    .s_out_valid(s_out_valid), .s_out_ready(s_out_ready),
    .s_out_bit(s_out_bit), .s_out_last(s_out_last), .busy(busy)
  );

  // Wrapper output is deliberately corrupted while a response is being shifted.
  assign dut_out_flat = ({1'b0, dut_in_flat[3:2]} + {1'b0, dut_in_flat[1:0]}) ^ garble;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: bits collected in a queue, a settle countdown, response queue.
  bit       m_in_q[$];
  bit       m_out_q[$];
  int       m_wait = 0;
  int       m_applied = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_q.delete();
      m_out_q.delete();
      m_wait = 0;
      m_applied = 0;
    end else if (m_out_q.size() != 0) begin
      if (s_out_ready) void'(m_out_q.pop_front());
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        int sum;
        sum = (m_applied / 4) + (m_applied % 4);
        for (int k = OUT_W - 1; k >= 0; k--) m_out_q.push_back(((sum >> k) & 1) == 1);
      end
    end else if (s_in_valid) begin
      m_in_q.push_back(s_in_bit);
      if (m_in_q.size() == IN_W) begin
        m_applied = 0;
        foreach (m_in_q[i]) m_applied = m_applied * 2 + int'(m_in_q[i]);
        m_in_q.delete();
        m_wait = SETTLE;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    garble = (m_out_q.size() != 0) ? OUT_W'($urandom) : '0;
  end

  always @(negedge clk) begin
    bit shifting;
    shifting = (m_out_q.size() != 0);
    chk("s_in_ready",  int'(s_in_ready),  int'(!shifting && m_wait == 0));
    chk("s_out_valid", int'(s_out_valid), int'(shifting));
    chk("s_out_bit",   int'(s_out_bit),   shifting ? int'(m_out_q[0]) : 0);
    chk("s_out_last",  int'(s_out_last),  int'(shifting && m_out_q.size() == 1));
    chk("busy",        int'(busy),        int'(shifting || m_wait > 0));
    chk("dut_in_flat", int'(dut_in_flat), m_applied);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    s_in_valid = 1'b1;
    while (!s_in_ready && t < 500) begin
      s_in_bit = 1'($urandom);
      tick();
      t++;
    end
    if (t >= 500) begin
      errors++;
      $display("FAIL send_timeout: s_in_ready stuck at %0d, required 1", s_in_ready);
    end
    s_in_bit = b;
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [IN_W-1:0] v, input int gap);
    for (int i = IN_W - 1; i >= 0; i--) begin
      send_bit(v[i]);
      if (i != 0) repeat (gap) begin
        s_in_bit = 1'($urandom);
        tick();
      end
    end
  endtask

  task automatic recv_resp(input int stall, output logic [OUT_W-1:0] r);
    r = '0;
    for (int k = 0; k < OUT_W; k++) begin
      int t = 0;
      s_out_ready = 1'b0;
      while (!s_out_valid && t < 500) begin
        tick();
        t++;
      end
      if (t >= 500) begin
        errors++;
        $display("FAIL recv_timeout: s_out_valid stuck at %0d, required 1", s_out_valid);
      end
      repeat (stall) tick();
      s_out_ready = 1'b1;
      r = {r[OUT_W-2:0], s_out_bit};
      tick();
      s_out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [OUT_W-1:0] r1, r2;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_ready", int'(s_in_ready), 1);
    chk("idle_valid", int'(s_out_valid), 0);
    chk("idle_din",   int'(dut_in_flat), 0);
    chk("idle_busy",  int'(busy), 0);

    send_vec(4'b1011, 0);
    chk("t2_din", int'(dut_in_flat), 4'b1011);
    recv_resp(0, r1);
    chk("t2_resp", int'(r1), 3'b101);

    send_vec(4'b1011, 2);
    recv_resp(0, r1);
    chk("t3_resp", int'(r1), 3'b101);

    send_vec(4'b1111, 0);
    recv_resp(3, r1);
    chk("t4_resp", int'(r1), 3'b110);

    send_vec(4'b1111, 0);
    while (!s_out_valid) tick();
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_din",   int'(dut_in_flat), 0);
    chk("t5_valid", int'(s_out_valid), 0);
    chk("t5_ready", int'(s_in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    send_vec(4'b0101, 0);
    recv_resp(0, r1);
    chk("t5_resp", int'(r1), 3'b010);

    fork
      begin
        send_vec(4'b0001, 0);
        send_vec(4'b1110, 0);
      end
      begin
        recv_resp(0, r1);
        recv_resp(0, r2);
      end
    join
    chk("t6_resp1", int'(r1), 3'b001);
    chk("t6_resp2", int'(r2), 3'b101);

    fork
      begin
        for (int n = 0; n < 40; n++) send_vec(IN_W'($urandom), $urandom_range(0, 2));
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 40 && cyc < 5000) begin
          s_out_ready = ($urandom_range(0, 2) != 0);
          if (s_out_valid && s_out_ready && s_out_last) got++;
          tick();
          cyc++;
        end
        s_out_ready = 1'b0;
        if (cyc >= 5000) begin
          errors++;
          $display("FAIL random_timeout: got %0d responses, required 40", got);
        end
      end
    join
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

endmodule
